core_bus_requester: RTL and testbench
=====================================

Name: core_bus_requester

Overview:
- Per-core initiator side of the shared-memory round-robin arbitration handshake. One instance per core per channel; the instruction channel ties core_write to 0.
- Accepts a single read or write from the core and raises Bus_RQ. After the arbiter grants the bus, it drives the shared memory bus and completes the Mem_Ready handshake.
- It releases the bus in the order the arbiter FSM expects: request low, then memory ready low, then grant low.

Parameters:
ADDR_WIDTH, 30, word address width
DATA_WIDTH, 32, data width
STRB_WIDTH, 4, byte-write strobe width

Ports:
clock  input  1  single clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
core_read  input  1  read request, sampled in IDLE
core_write  input  STRB_WIDTH  byte-write strobes, sampled in IDLE
core_address  input  ADDR_WIDTH  word address
core_wdata  input  DATA_WIDTH  write data
core_busy  output  1  high while an access is outstanding
core_done  output  1  one-cycle completion pulse
core_rdata  output  DATA_WIDTH  last read data, held
Bus_RQ  output  1  request line to the arbiter
Bus_GRANT  input  1  this core's grant bit from the arbiter
Mem_Ready  input  1  memory ready
Mem_rdata  input  DATA_WIDTH  memory read data
Mem_Read  output  1  shared bus, tri-state
Mem_Write  output  STRB_WIDTH  shared bus, tri-state
Mem_Address  output  ADDR_WIDTH  shared bus, tri-state
Mem_Out  output  DATA_WIDTH  shared bus, tri-state
protocol_error  output  1  sticky error flag

Behaviour:

Reset (reset=0, asynchronous):
- state=IDLE.
- Bus_RQ=0, core_busy=0, core_done=0, core_rdata=0, protocol_error=0.
- Latched request registers = 0.
- Mem_* outputs = z.
- Reset mid-transaction aborts immediately with the same values. The arbiter's own reset recovers its side.

Latching:
- In IDLE, a cycle with core_read=1 or core_write!=0 latches address, wdata and op.
- If both are active, the write wins and the read is dropped.
- Latched values are held until the return to IDLE. Core inputs are ignored while core_busy=1.

FSM:
- IDLE:
  - On request: go to REQ; Bus_RQ<=1, core_busy<=1.
- REQ:
  - Hold Bus_RQ=1.
  - Bus_GRANT=1 -> DRIVE.
- DRIVE:
  - Strobes active: Mem_Read=latched read, Mem_Write=latched strobes.
  - Mem_Address and Mem_Out are latched.
  - Mem_Ready=1 -> RELEASE. On that edge: if read, core_rdata<=Mem_rdata; Bus_RQ<=0.
- RELEASE:
  - Mem_Read=0, Mem_Write=0, address and data held.
  - Mem_Ready=0 -> GRANT_LOW.
- GRANT_LOW:
  - Strobes 0.
  - Bus_GRANT=0 -> IDLE; core_done<=1 for one cycle, core_busy<=0.
- A new request may be latched in the cycle after core_done.

Bus drive enable:
- Combinational: Bus_GRANT=1 and state in {DRIVE, RELEASE, GRANT_LOW}.
- Otherwise all Mem_* outputs are z; the arbiter drives 0 while the bus is idle.
- Grant arrives one cycle before strobes. The memory sees strobes no earlier than the cycle after grant.

Latency:
- Minimum from request cycle to core_done: 5 cycles plus grant wait plus memory latency.

Protocol error (sticky until reset):
- Bus_GRANT=1 while in IDLE or in REQ before Bus_RQ has been driven: bus stays z.
- Bus_GRANT falls while in DRIVE or RELEASE: outputs go z immediately and the state is held until grant returns.
- Mem_Ready=1 observed in REQ while granted is tolerated, with no error.

Simultaneous events:
- Mem_Ready rising and Bus_GRANT falling in the same DRIVE cycle: flag the error; the data capture still occurs.

Test Plan:
- Read, grant after 3 cycles, Mem_Ready high 2 cycles after strobe, Mem_rdata=0xDEADBEEF:
  - Bus_RQ rises on cycle 1 and falls on the Ready edge.
  - Mem_Read=1 only during DRIVE.
  - core_rdata=0xDEADBEEF, a single core_done pulse, Mem_* z after grant drops.
- Write, strobes 4'b0011, addr 0x0000100, data 0x12345678:
  - Bus shows exactly these values during DRIVE.
  - Strobes return to 0 in RELEASE, address held until grant low.
  - core_rdata unchanged.
- Read and write simultaneously in IDLE with strobes 4'b1111: a write is performed and Mem_Read stays 0.
- Four instances under the arbiter, all requesting at once:
  - Grants are served round-robin in order 0,1,2,3.
  - Each instance sees exactly one core_done.
  - The shared bus is never driven by two instances at once (no X).
- Grant dropped mid-DRIVE: protocol_error=1, Mem_* z; on regrant the access completes.
- reset=0 asserted during RELEASE: all outputs at reset values asynchronously; after release, a new read completes normally.

Source files
------------

// File: rtl/core_bus_requester.sv
// -----------------------------------------------------------------------------
// core_bus_requester
//
// Initiator side of the shared-memory round-robin arbitration handshake, one
// instance per core per channel. It accepts one read or write from the core and
// raises Bus_RQ. Once granted, it drives the shared memory bus and completes
// the Mem_Ready handshake. It then releases the bus in the order the arbiter
// FSM expects: request low, then memory ready low, then grant low.
//
// Ports
//   clock, reset                  rising-edge clock, async active-low reset
//   core_read/core_write          request from the core, sampled in IDLE only
//   core_address/core_wdata       word address and write data, latched with op
//   core_busy                     access outstanding
//   core_done                     one-cycle completion pulse
//   core_rdata                    last read data, held between reads
//   Bus_RQ / Bus_GRANT            request to / grant from the arbiter
//   Mem_Ready / Mem_rdata         memory handshake and read data
//   Mem_Read/Mem_Write/
//   Mem_Address/Mem_Out           shared tri-state bus, driven only while granted
//   protocol_error                sticky arbiter-protocol violation flag
// -----------------------------------------------------------------------------
module core_bus_requester #(
  parameter int ADDR_WIDTH = 30,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  core_read,
  input  logic [STRB_WIDTH-1:0] core_write,
  input  logic [ADDR_WIDTH-1:0] core_address,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  output logic                  core_busy,
  output logic                  core_done,
  output logic [DATA_WIDTH-1:0] core_rdata,
  output logic                  Bus_RQ,
  input  logic                  Bus_GRANT,
  input  logic                  Mem_Ready,
  input  logic [DATA_WIDTH-1:0] Mem_rdata,
  output wire                   Mem_Read,
  output wire  [STRB_WIDTH-1:0] Mem_Write,
  output wire  [ADDR_WIDTH-1:0] Mem_Address,
  output wire  [DATA_WIDTH-1:0] Mem_Out,
  output logic                  protocol_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_DRIVE,
    S_RELEASE,
    S_GRANT_LOW
  } state_t;

  // ---------------------------------------------------------------------------
  // State and latched request
  // ---------------------------------------------------------------------------
  state_t                r_state;
  logic                  r_bus_rq;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_op_read;
  logic [STRB_WIDTH-1:0] r_strb;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;

  state_t                w_state_next;
  logic                  w_req;
  logic                  w_latch;
  logic                  w_capture;
  logic                  w_finish;
  logic                  w_err_set;
  logic                  w_bus_en;
  logic                  w_strobe_phase;

  // A request is any read or any non-zero strobe. It is not accepted during
  // the core_done cycle, so a core that holds its request until it sees done
  // does not get a duplicate access.
  assign w_req = (core_read || (core_write != '0)) && !r_done;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_latch      = 1'b0;
    w_capture    = 1'b0;
    w_finish     = 1'b0;
    w_err_set    = 1'b0;

    case (r_state)
      S_IDLE: begin
        // A grant we never asked for. The bus stays z because the drive
        // enable excludes IDLE.
        if (Bus_GRANT) begin
          w_err_set = 1'b1;
        end
        if (w_req) begin
          w_latch      = 1'b1;
          w_state_next = S_REQ;
        end
      end

      S_REQ: begin
        // Bus_RQ is registered on the REQ entry edge, so a grant seen with
        // Bus_RQ still low is a grant for a request that was never made.
        // Mem_Ready here belongs to someone else's access and is ignored.
        if (Bus_GRANT && !r_bus_rq) begin
          w_err_set = 1'b1;
        end else if (Bus_GRANT) begin
          w_state_next = S_DRIVE;
        end
      end

      S_DRIVE: begin
        // Losing the grant here is an error. The bus goes z at once through
        // the drive enable and the state is held until the grant returns.
        // If Mem_Ready arrives in the same cycle, the data is still taken.
        if (!Bus_GRANT) begin
          w_err_set = 1'b1;
        end
        if (Mem_Ready) begin
          w_capture    = 1'b1;
          w_state_next = S_RELEASE;
        end
      end

      S_RELEASE: begin
        if (!Bus_GRANT) begin
          w_err_set = 1'b1;
        end else if (!Mem_Ready) begin
          w_state_next = S_GRANT_LOW;
        end
      end

      S_GRANT_LOW: begin
        if (!Bus_GRANT) begin
          w_finish     = 1'b1;
          w_state_next = S_IDLE;
        end
      end

      default: w_state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: non-blocking assignments throughout, so every register samples the
  // values from before the edge regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_bus_rq  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_rdata   <= '0;
      // NOTE: the latched request is plain flops rather than a memory, and it
      // is cleared on reset so nothing stale can reach the bus after an abort.
      r_op_read <= 1'b0;
      r_strb    <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_finish;

      if (w_latch) begin
        r_bus_rq  <= 1'b1;
        r_busy    <= 1'b1;
        r_addr    <= core_address;
        r_wdata   <= core_wdata;
        r_strb    <= core_write;
        // If both are active, the write wins and the read is dropped.
        r_op_read <= core_read && (core_write == '0);
      end

      if (w_capture) begin
        r_bus_rq <= 1'b0;
        if (r_op_read) begin
          r_rdata <= Mem_rdata;
        end
      end

      if (w_finish) begin
        r_busy <= 1'b0;
      end

      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Shared bus drive
  // ---------------------------------------------------------------------------
  // The enable is combinational on Bus_GRANT, so a dropped grant floats the
  // bus in the same cycle. The state is REQ in the cycle the grant arrives,
  // so the strobes never appear before the cycle after the grant.
  assign w_bus_en       = Bus_GRANT &&
                          (r_state inside {S_DRIVE, S_RELEASE, S_GRANT_LOW});
  assign w_strobe_phase = (r_state == S_DRIVE);

  assign Mem_Read    = w_bus_en ? (w_strobe_phase && r_op_read) : 1'bz;
  assign Mem_Write   = w_bus_en ? (w_strobe_phase ? r_strb : '0) : 'z;
  assign Mem_Address = w_bus_en ? r_addr  : 'z;
  assign Mem_Out     = w_bus_en ? r_wdata : 'z;

  assign core_busy      = r_busy;
  assign core_done      = r_done;
  assign core_rdata     = r_rdata;
  assign Bus_RQ         = r_bus_rq;
  assign protocol_error = r_err;

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  a_done_single : assert property (@(posedge clock) disable iff (!reset)
                                   core_done |=> !core_done);
  a_done_idle   : assert property (@(posedge clock) disable iff (!reset)
                                   core_done |-> !core_busy);
  a_rq_busy     : assert property (@(posedge clock) disable iff (!reset)
                                   Bus_RQ |-> core_busy);
  a_rd_wr_excl  : assert property (@(posedge clock) disable iff (!reset)
                                   (r_state == S_DRIVE && r_op_read) |-> (r_strb == '0));

endmodule

// File: tb/tb_core_bus_requester.sv
module tb_core_bus_requester;

  // ---------------------------------------------------------------------------
  // Clock, reset, single instance
  // ---------------------------------------------------------------------------
  logic        clock;
  logic        reset;
  logic        core_read;
  logic [3:0]  core_write;
  logic [29:0] core_address;
  logic [31:0] core_wdata;
  logic        core_busy;
  logic        core_done;
  logic [31:0] core_rdata;
  logic        bus_rq;
  logic        grant;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  wire         mem_read;
  wire  [3:0]  mem_write;
  wire  [29:0] mem_address;
  wire  [31:0] mem_out;
  logic        protocol_error;
  wire         en0;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  core_bus_requester u_dut (
    .clock          (clock),
    .reset          (reset),
    .core_read      (core_read),
    .core_write     (core_write),
    .core_address   (core_address),
    .core_wdata     (core_wdata),
    .core_busy      (core_busy),
    .core_done      (core_done),
    .core_rdata     (core_rdata),
    .Bus_RQ         (bus_rq),
    .Bus_GRANT      (grant),
    .Mem_Ready      (mem_ready),
    .Mem_rdata      (mem_rdata),
    .Mem_Read       (mem_read),
    .Mem_Write      (mem_write),
    .Mem_Address    (mem_address),
    .Mem_Out        (mem_out),
    .protocol_error (protocol_error)
  );

  // Drive enable of the instance: a z on the bus is checked through it.
  assign en0 = u_dut.w_bus_en;

  // ---------------------------------------------------------------------------
  // Four instances on one shared bus
  // ---------------------------------------------------------------------------
  logic [3:0]  rd4;
  logic [3:0]  gnt4;
  logic        m_ready4;
  logic [31:0] m_rdata4;
  wire         m_read4;
  wire  [3:0]  m_write4;
  wire  [29:0] m_addr4;
  wire  [31:0] m_out4;
  wire  [3:0]  busy4;
  wire  [3:0]  done4;
  wire  [3:0]  rq4;
  wire  [3:0]  err4;
  wire  [3:0]  en4;
  wire  [31:0] rdata4 [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_core
    core_bus_requester u_req (
      .clock          (clock),
      .reset          (reset),
      .core_read      (rd4[gi]),
      .core_write     (4'b0000),
      .core_address   (30'(gi * 16)),
      .core_wdata     (32'h0),
      .core_busy      (busy4[gi]),
      .core_done      (done4[gi]),
      .core_rdata     (rdata4[gi]),
      .Bus_RQ         (rq4[gi]),
      .Bus_GRANT      (gnt4[gi]),
      .Mem_Ready      (m_ready4),
      .Mem_rdata      (m_rdata4),
      .Mem_Read       (m_read4),
      .Mem_Write      (m_write4),
      .Mem_Address    (m_addr4),
      .Mem_Out        (m_out4),
      .protocol_error (err4[gi])
    );
    assign en4[gi] = u_req.w_bus_en;
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: each completion pops the expected response.
  always @(negedge clock) begin
    exp_t e;
    if (core_done === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got a done pulse, expected none at %0t", $time);
      end else begin
        e = sb.pop_front();
        check("sb_rdata", core_rdata, e.rdata);
        check("sb_err", {31'b0, protocol_error}, {31'b0, e.err});
      end
    end
  end

  // One full access on the single instance. The bench acts as arbiter and
  // memory with fixed timing, so no step waits on the DUT.
  task automatic access(input logic rd, input logic [3:0] strb, input logic [29:0] a,
                        input logic [31:0] d, input int gwait, input int mlat,
                        input bit drop, input logic [31:0] md,
                        input logic [31:0] exp_rdata, input logic exp_err);
    logic exp_read;
    exp_t e;
    exp_read = rd && (strb == 4'b0000);
    e.rdata  = exp_rdata;
    e.err    = exp_err;
    sb.push_back(e);

    core_read = rd; core_write = strb; core_address = a; core_wdata = d;
    @(posedge clock); #1;
    // The core inputs are ignored while busy, so drive garbage on them.
    core_read = 1'b1; core_write = 4'hF; core_address = ~a; core_wdata = ~d;
    check("rq_rise", {31'b0, bus_rq}, 1);
    check("busy_rise", {31'b0, core_busy}, 1);
    for (int i = 0; i < gwait; i++) begin
      check("req_bus_z", {31'b0, en0}, 0);
      @(posedge clock); #1;
    end
    grant = 1'b1; #1;
    check("grant_cycle_z", {31'b0, en0}, 0);
    @(posedge clock); #1;
    if (drop) begin
      grant = 1'b0; #1;
      check("drop_bus_z", {31'b0, en0}, 0);
      @(posedge clock); #1;
      check("drop_err", {31'b0, protocol_error}, 1);
      check("drop_hold_rq", {31'b0, bus_rq}, 1);
      check("drop_still_z", {31'b0, en0}, 0);
      grant = 1'b1; #1;
      check("regrant_en", {31'b0, en0}, 1);
    end
    for (int i = 0; i < mlat; i++) begin
      check("drv_en", {31'b0, en0}, 1);
      check("drv_read", {31'b0, mem_read}, {31'b0, exp_read});
      check("drv_write", {28'b0, mem_write}, {28'b0, strb});
      check("drv_addr", {2'b0, mem_address}, {2'b0, a});
      check("drv_data", mem_out, d);
      @(posedge clock); #1;
    end
    mem_ready = 1'b1; mem_rdata = md;
    check("drv_read_last", {31'b0, mem_read}, {31'b0, exp_read});
    check("drv_write_last", {28'b0, mem_write}, {28'b0, strb});
    check("drv_addr_last", {2'b0, mem_address}, {2'b0, a});
    @(posedge clock); #1;
    mem_ready = 1'b0; mem_rdata = 32'h0;
    check("rel_rq_low", {31'b0, bus_rq}, 0);
    check("rel_en", {31'b0, en0}, 1);
    check("rel_read0", {31'b0, mem_read}, 0);
    check("rel_write0", {28'b0, mem_write}, 0);
    check("rel_addr", {2'b0, mem_address}, {2'b0, a});
    @(posedge clock); #1;
    core_read = 1'b0; core_write = 4'h0; core_address = '0; core_wdata = '0;
    check("gl_en", {31'b0, en0}, 1);
    check("gl_write0", {28'b0, mem_write}, 0);
    check("gl_addr", {2'b0, mem_address}, {2'b0, a});
    check("gl_busy", {31'b0, core_busy}, 1);
    grant = 1'b0; #1;
    check("gl_drop_z", {31'b0, en0}, 0);
    @(posedge clock); #1;
    check("done_pulse", {31'b0, core_done}, 1);
    check("done_busy", {31'b0, core_busy}, 0);
    @(posedge clock); #1;
    check("done_single", {31'b0, core_done}, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int          ndone [4];
  int          order [$];
  int          owner;
  int          last;
  int          phase;
  int          pick;
  bit          a_busy;

  initial begin
    reset = 1'b0;
    core_read = 1'b0; core_write = 4'h0; core_address = '0; core_wdata = '0;
    grant = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    rd4 = 4'h0; gnt4 = 4'h0; m_ready4 = 1'b0; m_rdata4 = '0;

    repeat (2) @(posedge clock);
    #1;
    check("rst_rq", {31'b0, bus_rq}, 0);
    check("rst_busy", {31'b0, core_busy}, 0);
    check("rst_done", {31'b0, core_done}, 0);
    check("rst_rdata", core_rdata, 0);
    check("rst_err", {31'b0, protocol_error}, 0);
    check("rst_bus_z", {31'b0, en0}, 0);
    reset = 1'b1;
    @(posedge clock); #1;

    // Read: grant after 3 cycles, ready 2 cycles after strobe.
    access(1'b1, 4'b0000, 30'h155, 32'h0, 3, 2, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
    // Write with strobes 0011; core_rdata must not change.
    access(1'b0, 4'b0011, 30'h0000100, 32'h12345678, 1, 1, 1'b0, 32'hCAFEF00D, 32'hDEADBEEF, 1'b0);
    // Read and write together: the write wins, Mem_Read stays 0.
    access(1'b1, 4'b1111, 30'h2AA, 32'h0F0F0F0F, 0, 0, 1'b0, 32'h55555555, 32'hDEADBEEF, 1'b0);
    // Grant dropped mid-DRIVE: error, bus z, the access completes on regrant.
    access(1'b1, 4'b0000, 30'h3A, 32'h0, 2, 1, 1'b1, 32'h13579BDF, 32'h13579BDF, 1'b1);

    // Reset asserted during RELEASE.
    core_read = 1'b1; core_address = 30'h44;
    @(posedge clock); #1;
    core_read = 1'b0;
    grant = 1'b1;
    @(posedge clock); #1;
    mem_ready = 1'b1; mem_rdata = 32'hFFFF0000;
    @(posedge clock); #1;
    check("pre_rst_rel_en", {31'b0, en0}, 1);
    #2 reset = 1'b0;
    #1;
    check("arst_rq", {31'b0, bus_rq}, 0);
    check("arst_busy", {31'b0, core_busy}, 0);
    check("arst_done", {31'b0, core_done}, 0);
    check("arst_rdata", core_rdata, 0);
    check("arst_err", {31'b0, protocol_error}, 0);
    check("arst_bus_z", {31'b0, en0}, 0);
    mem_ready = 1'b0; mem_rdata = '0; grant = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;

    // A new read after reset completes at minimum latency.
    access(1'b1, 4'b0000, 30'h77, 32'h0, 0, 0, 1'b0, 32'h2468ACE0, 32'h2468ACE0, 1'b0);

    // A grant in IDLE is a protocol error and the bus stays z.
    grant = 1'b1; #1;
    check("idle_grant_z", {31'b0, en0}, 0);
    @(posedge clock); #1;
    check("idle_grant_err", {31'b0, protocol_error}, 1);
    grant = 1'b0;
    @(posedge clock); #1;

    // Four instances request at once under a round-robin arbiter model.
    for (int i = 0; i < 4; i++) ndone[i] = 0;
    order.delete();
    a_busy = 1'b0; owner = 0; last = 3; phase = 0;
    rd4 = 4'hF;
    @(posedge clock); #1;
    rd4 = 4'h0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      check("bus_excl", {31'b0, ($countones(en4) <= 1)}, 1);
      for (int i = 0; i < 4; i++) begin
        if (done4[i] === 1'b1) begin
          ndone[i]++;
          check("rr_rdata", rdata4[i], 32'hA000_0000 | i);
        end
      end
      if (!a_busy) begin
        for (int k = 1; k <= 4; k++) begin
          pick = (last + k) % 4;
          if (!a_busy && rq4[pick] === 1'b1) begin
            a_busy = 1'b1;
            owner  = pick;
            gnt4   = 4'(1 << pick);
            order.push_back(pick);
          end
        end
      end else begin
        case (phase)
          0: if (m_read4 === 1'b1) begin
               check("rr_addr", {2'b0, m_addr4}, owner * 16);
               check("rr_write0", {28'b0, m_write4}, 0);
               check("rr_out", m_out4, 0);
               m_ready4 = 1'b1;
               m_rdata4 = 32'hA000_0000 | owner;
               phase    = 1;
             end
          1: if (rq4[owner] === 1'b0) begin
               m_ready4 = 1'b0;
               m_rdata4 = '0;
               phase    = 2;
             end
          default: begin
            gnt4   = 4'h0;
            a_busy = 1'b0;
            last   = owner;
            phase  = 0;
          end
        endcase
      end
      @(posedge clock); #1;
    end
    check("rr_served", order.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check("rr_done_once", ndone[i], 1);
      if (i < order.size()) check("rr_order", order[i], i);
    end
    check("rr_err", {28'b0, err4}, 0);
    check("rr_busy", {28'b0, busy4}, 0);

    @(negedge clock);
    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
